// File: rtl/multi_edge_detector.sv
// rtl/multi_edge_detector.sv - synchronised, glitch-filtered multi-channel edge detector with sticky irq
// Optional per-channel saturating event counters (evt_cnt) when EDGE_DET_CNT_EN is defined.
module multi_edge_detector #(
    parameter int CH          = 4,
    parameter int SYNC_STAGES = 2,
    parameter int FILT_W      = 4,
    parameter int CNT_W       = 8
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [CH-1:0]       sig_in,
    input  logic [2*CH-1:0]     mode,
    input  logic [FILT_W-1:0]   filt_len,
    input  logic [CH-1:0]       irq_clr,
    output logic [CH-1:0]       level_out,
    output logic [CH-1:0]       pulse_out_p,
    output logic [CH-1:0]       pulse_out_n,
    output logic [CH-1:0]       evt_pending,
`ifdef EDGE_DET_CNT_EN
    output logic [CH*CNT_W-1:0] evt_cnt,
`endif
    output logic                irq
);

    if (CH < 1 || CH > 32 || SYNC_STAGES < 2 || SYNC_STAGES > 4 || FILT_W < 1 || CNT_W < 1) begin : g_bad_param
        $error("multi_edge_detector: parameter out of range");
    end

    logic [CH-1:0]     sync_q [SYNC_STAGES];
    logic [FILT_W-1:0] filt_cnt_q [CH];
    logic [CH-1:0]     s;
    logic [CH-1:0]     commit;
    logic [CH-1:0]     qual_p;
    logic [CH-1:0]     qual_n;

    // A level change commits once s has disagreed with f for filt_len+1 edges;
    // the >= compare makes a shortened filt_len commit immediately.
    always_comb begin
        s      = sync_q[SYNC_STAGES-1];
        commit = '0;
        qual_p = '0;
        qual_n = '0;
        for (int i = 0; i < CH; i++) begin
            commit[i] = (s[i] != level_out[i]) && (filt_cnt_q[i] >= filt_len);
            qual_p[i] = commit[i] &  s[i] & mode[2*i];
            qual_n[i] = commit[i] & ~s[i] & mode[2*i+1];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int j = 0; j < SYNC_STAGES; j++) begin
                sync_q[j] <= '0;
            end
            for (int i = 0; i < CH; i++) begin
                filt_cnt_q[i] <= '0;
            end
            level_out   <= '0;
            pulse_out_p <= '0;
            pulse_out_n <= '0;
            evt_pending <= '0;
            irq         <= 1'b0;
        end else begin
            sync_q[0] <= sig_in;
            for (int j = 1; j < SYNC_STAGES; j++) begin
                sync_q[j] <= sync_q[j-1];
            end
            for (int i = 0; i < CH; i++) begin
                if ((s[i] == level_out[i]) || commit[i]) begin
                    filt_cnt_q[i] <= '0;
                end else begin
                    filt_cnt_q[i] <= filt_cnt_q[i] + FILT_W'(1);
                end
            end
            level_out   <= level_out ^ commit;
            pulse_out_p <= qual_p;
            pulse_out_n <= qual_n;
            // set wins over a same-cycle clear so no event is lost
            evt_pending <= (evt_pending & ~irq_clr) | qual_p | qual_n;
            irq         <= |evt_pending;
        end
    end

`ifdef EDGE_DET_CNT_EN
    logic [CNT_W-1:0] evt_cnt_q [CH];

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < CH; i++) begin
                evt_cnt_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < CH; i++) begin
                if (irq_clr[i]) begin
                    evt_cnt_q[i] <= CNT_W'(qual_p[i] | qual_n[i]);
                end else if ((qual_p[i] | qual_n[i]) && (evt_cnt_q[i] != {CNT_W{1'b1}})) begin
                    evt_cnt_q[i] <= evt_cnt_q[i] + CNT_W'(1);
                end
            end
        end
    end

    always_comb begin
        evt_cnt = '0;
        for (int i = 0; i < CH; i++) begin
            evt_cnt[i*CNT_W +: CNT_W] = evt_cnt_q[i];
        end
    end
`endif

endmodule
